// File: rtl/gpio_input_controller.sv
// Memory-mapped GPIO input port for the multicycle MIPS. Pins are synchronized, debounced as one bus
// and rising edges are latched in sticky flags. Both are readable by lw with one-cycle latency.
module gpio_input_controller #(
  parameter int                    DATA_WIDTH      = 8,
  parameter int                    ADDR_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] GPIO_IN_ADDR    = 32'h1001_0028,
  parameter logic [ADDR_WIDTH-1:0] GPIO_EDGE_ADDR  = 32'h1001_002C,
  parameter int                    DEBOUNCE_CYCLES = 4,
  parameter int                    CNT_WIDTH       = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] gpio_pins,
  input  logic [ADDR_WIDTH-1:0] addr_ram,
  input  logic                  enable_lw,
  output logic [31:0]           rdata,
  output logic                  data_sel,
  output logic [DATA_WIDTH-1:0] gpio_stable,
  output logic                  edge_pending
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [DATA_WIDTH-1:0] r_sync1;
  logic [DATA_WIDTH-1:0] r_sync2;
  logic [DATA_WIDTH-1:0] r_sync_prev;
  logic [DATA_WIDTH-1:0] r_stable;
  logic [DATA_WIDTH-1:0] r_flags;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [31:0]           r_rdata;
  logic                  r_data_sel;

  logic                  w_hit_in;
  logic                  w_hit_edge;
  logic [DATA_WIDTH-1:0] w_stable_nxt;
  logic [CNT_WIDTH-1:0]  w_cnt_nxt;
  logic [DATA_WIDTH-1:0] w_rise;
  logic [DATA_WIDTH-1:0] w_clr;
  logic [31:0]           w_rdata_nxt;
  logic                  w_data_sel_nxt;

  // Word-address decode: byte-offset bits [1:0] never take part in the match.
  assign w_hit_in   = enable_lw && (addr_ram[ADDR_WIDTH-1:2] == GPIO_IN_ADDR[ADDR_WIDTH-1:2]);
  assign w_hit_edge = enable_lw && (addr_ram[ADDR_WIDTH-1:2] == GPIO_EDGE_ADDR[ADDR_WIDTH-1:2]);

  // Debounce: any movement, or a value equal to the accepted one, restarts the count.
  always_comb begin
    w_stable_nxt = r_stable;
    w_cnt_nxt    = '0;
    if ((r_sync2 != r_sync_prev) || (r_sync2 == r_stable)) begin
      w_cnt_nxt = '0;
    end else if (r_cnt == CNT_LAST) begin
      w_stable_nxt = r_sync2;
      w_cnt_nxt    = '0;
    end else begin
      w_cnt_nxt = r_cnt + CNT_ONE;
    end
  end

  // Set wins over clear so an edge committed in the reading cycle is not lost.
  assign w_rise = w_stable_nxt & ~r_stable;
  assign w_clr  = w_hit_edge ? r_flags : '0;

  // Read mux; the edge read returns the flags before they are cleared.
  always_comb begin
    w_rdata_nxt    = 32'h0000_0000;
    w_data_sel_nxt = 1'b0;
    if (w_hit_in) begin
      w_rdata_nxt    = 32'(r_stable);
      w_data_sel_nxt = 1'b1;
    end else if (w_hit_edge) begin
      w_rdata_nxt    = 32'(r_flags);
      w_data_sel_nxt = 1'b1;
    end else begin
      w_rdata_nxt    = 32'h0000_0000;
      w_data_sel_nxt = 1'b0;
    end
  end

  // Synchronizer, debounce state and accepted pin value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_sync_prev <= '0;
      r_cnt       <= '0;
      r_stable    <= '0;
    end else begin
      r_sync1     <= gpio_pins;
      r_sync2     <= r_sync1;
      r_sync_prev <= r_sync2;
      r_cnt       <= w_cnt_nxt;
      r_stable    <= w_stable_nxt;
    end
  end

  // Sticky rising-edge flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= '0;
    end else begin
      r_flags <= (r_flags & ~w_clr) | w_rise;
    end
  end

  // Registered read response toward the data-register mux.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata    <= 32'h0000_0000;
      r_data_sel <= 1'b0;
    end else begin
      r_rdata    <= w_rdata_nxt;
      r_data_sel <= w_data_sel_nxt;
    end
  end

  assign rdata        = r_rdata;
  assign data_sel     = r_data_sel;
  assign gpio_stable  = r_stable;
  assign edge_pending = |r_flags;

endmodule

// File: tb/tb_gpio_input_controller.sv
// Bench for gpio_input_controller: directed scenarios followed by random pins and reads, all
// checked against a reference model that reasons in terms of held levels and sticky flags.
module tb_gpio_input_controller;

  localparam int          D      = 4;
  localparam logic [31:0] IN_A   = 32'h1001_0028;
  localparam logic [31:0] EDGE_A = 32'h1001_002C;
  localparam logic [31:0] MISS_A = 32'h1001_0030;
  localparam logic [31:0] RAM_A  = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  gpio_pins = 8'h00;
  logic [31:0] addr_ram = 32'h0;
  logic        enable_lw = 1'b0;
  logic [31:0] rdata;
  logic        data_sel;
  logic [7:0]  gpio_stable;
  logic        edge_pending;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [7:0]  pin_q[$];
  logic [7:0]  win[$];
  logic [7:0]  m_stable;
  logic [7:0]  m_flags;
  logic [31:0] m_rdata;
  logic        m_sel;

  gpio_input_controller dut (
    .clk(clk), .reset(reset), .gpio_pins(gpio_pins), .addr_ram(addr_ram),
    .enable_lw(enable_lw), .rdata(rdata), .data_sel(data_sel),
    .gpio_stable(gpio_stable), .edge_pending(edge_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pin_q = '{8'h00, 8'h00};
    win.delete();
    m_stable = 8'h00;
    m_flags  = 8'h00;
    m_rdata  = 32'h0;
    m_sel    = 1'b0;
  endtask

  task automatic chk_all();
    chk("rdata", rdata, m_rdata);
    chk("data_sel", {31'h0, data_sel}, {31'h0, m_sel});
    chk("gpio_stable", {24'h0, gpio_stable}, {24'h0, m_stable});
    chk("edge_pending", {31'h0, edge_pending}, {31'h0, (m_flags != 8'h00)});
  endtask

  // One clock edge: advance the model from the inputs seen at the edge, then compare.
  task automatic tick();
    logic [7:0]  sd, rise, clr;
    logic [29:0] wa;
    bit          hit_in, hit_edge, all_eq;
    @(posedge clk);
    wa       = addr_ram[31:2];
    hit_in   = enable_lw && (wa == (IN_A >> 2));
    hit_edge = enable_lw && (wa == (EDGE_A >> 2));
    m_sel    = hit_in || hit_edge;
    m_rdata  = hit_in ? {24'h0, m_stable} : (hit_edge ? {24'h0, m_flags} : 32'h0);
    clr      = hit_edge ? m_flags : 8'h00;
    // pins reach the debounce logic two edges after being sampled
    sd = pin_q.pop_front();
    pin_q.push_back(gpio_pins);
    win.push_back(sd);
    if (win.size() > D + 1) void'(win.pop_front());
    all_eq = 1'b1;
    foreach (win[i]) if (win[i] !== win[0]) all_eq = 1'b0;
    rise = 8'h00;
    if (all_eq && (win.size() == D + 1) && (win[0] != m_stable)) begin
      rise     = win[0] & ~m_stable;
      m_stable = win[0];
    end
    m_flags = (m_flags & ~clr) | rise;
    #1;
    chk_all();
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic lw(input logic [31:0] a);
    addr_ram  = a;
    enable_lw = 1'b1;
    tick();
    enable_lw = 1'b0;
    addr_ram  = 32'h0;
  endtask

  initial begin
    model_reset();
    // Reset state
    @(posedge clk);
    #1;
    chk_all();
    chk("reset_stable", {24'h0, gpio_stable}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // A5 held from before edge 1 is accepted at edge 7
    gpio_pins = 8'hA5;
    hold(6);
    chk("a5_edge6", {24'h0, gpio_stable}, 32'h0);
    tick();
    chk("a5_edge7", {24'h0, gpio_stable}, 32'hA5);
    chk("a5_pending", {31'h0, edge_pending}, 32'h1);
    lw(EDGE_A);
    chk("a5_flags", rdata, 32'hA5);

    // Back to 0, then glitch rejection and a just-long-enough pulse
    gpio_pins = 8'h00;
    hold(8);
    gpio_pins = 8'h01; hold(3);
    gpio_pins = 8'h00; hold(8);
    chk("pulse3_stable", {24'h0, gpio_stable}, 32'h0);
    chk("pulse3_flags", {31'h0, edge_pending}, 32'h0);
    gpio_pins = 8'h01; hold(5);
    gpio_pins = 8'h00; hold(2);
    chk("pulse5_rise", {24'h0, gpio_stable}, 32'h01);
    hold(6);
    chk("pulse5_fall", {24'h0, gpio_stable}, 32'h0);

    // Pin-value reads are repeatable and side-effect free
    gpio_pins = 8'h3C;
    hold(8);
    lw(IN_A);
    chk("in_read1", rdata, 32'h3C);
    lw(IN_A);
    chk("in_read2", rdata, 32'h3C);
    tick();
    chk("sel_one_cycle", {31'h0, data_sel}, 32'h0);

    // Clear-on-read of flags = 05
    gpio_pins = 8'h00; hold(8);
    lw(EDGE_A);
    gpio_pins = 8'h05; hold(8);
    lw(EDGE_A);
    chk("edge_read05", rdata, 32'h05);
    lw(EDGE_A);
    chk("edge_read0", rdata, 32'h0);

    // Rising edge committed in the clearing cycle stays set
    gpio_pins = 8'h04; hold(8);
    gpio_pins = 8'h05; hold(8);
    lw(EDGE_A);
    chk("flags01", rdata, 32'h01);
    gpio_pins = 8'h05; hold(8);
    gpio_pins = 8'h04; hold(8);
    lw(EDGE_A);
    gpio_pins = 8'h05; hold(8);
    gpio_pins = 8'h07;
    hold(6);
    lw(EDGE_A);
    chk("collide_read", rdata, 32'h01);
    lw(EDGE_A);
    chk("collide_after", rdata, 32'h02);

    // Misses and ignored byte offset
    lw(MISS_A);
    chk("miss_sel", {31'h0, data_sel}, 32'h0);
    lw(RAM_A);
    chk("ram_rdata", rdata, 32'h0);
    lw(IN_A | 32'h3);
    chk("offset_in", rdata, 32'h07);
    lw(EDGE_A | 32'h2);
    chk("offset_edge_sel", {31'h0, data_sel}, 32'h1);

    // Asynchronous reset at debounce count 2
    gpio_pins = 8'hFF; hold(8);
    gpio_pins = 8'h0F;
    hold(4);
    lw(IN_A);
    chk("pre_reset_read", rdata, 32'hFF);
    #2;
    reset = 1'b1;
    #1;
    chk("async_stable", {24'h0, gpio_stable}, 32'h0);
    chk("async_rdata", rdata, 32'h0);
    chk("async_sel", {31'h0, data_sel}, 32'h0);
    chk("async_pending", {31'h0, edge_pending}, 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    hold(6);
    chk("requal_edge6", {24'h0, gpio_stable}, 32'h0);
    tick();
    chk("requal_edge7", {24'h0, gpio_stable}, 32'h0F);

    // Random pins (long holds mixed with glitches) and random reads
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) gpio_pins = 8'($urandom_range(0, 255));
      enable_lw = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0:       addr_ram = IN_A;
        1:       addr_ram = EDGE_A;
        2:       addr_ram = MISS_A;
        default: addr_ram = RAM_A;
      endcase
      addr_ram = addr_ram | 32'($urandom_range(0, 3));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpio_input_controller.md
Name: gpio_input_controller

Overview:
Memory-mapped GPIO input (read) port for the multicycle MIPS. It is the load-side counterpart of the GPIO output controller. It samples external pins, synchronizes and debounces them, and latches rising edges in sticky flags. It returns either the debounced value or the edge flags when the core executes an lw to one of its two addresses. It sits beside the RAM on the ALUOut address bus, and its data_sel output drives the mux in front of the data register.

Parameters:
DATA_WIDTH, 8, number of GPIO input pins
ADDR_WIDTH, 32, width of the address bus (ALUOut)
GPIO_IN_ADDR, 32'h1001_0028, word address returning the debounced pin value
GPIO_EDGE_ADDR, 32'h1001_002C, word address returning the rising-edge flags (clear-on-read)
DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a change (minimum 2)
CNT_WIDTH, 3, debounce counter width; must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
gpio_pins  in  DATA_WIDTH  raw external inputs, asynchronous to clk
addr_ram  in  ADDR_WIDTH  data address from ALUOut
enable_lw  in  1  control unit flag: current instruction is lw in its memory-read state
rdata  out  32  read data, zero-extended, registered
data_sel  out  1  1 = rdata is valid for this access (selects GPIO over RAM q), registered
gpio_stable  out  DATA_WIDTH  current debounced pin value
edge_pending  out  1  OR of all edge flags

Behaviour:
- Reset (asynchronous, active-high): all internal registers and all outputs go to 0. This covers sync stages, sync_prev, cnt, gpio_stable, edge flags, rdata and data_sel.
- Synchronizer: two flops per bit, giving sync_d.
- Debounce (whole bus, one counter):
  - Third register sync_prev <= sync_d every cycle.
  - If sync_d != sync_prev, or sync_d == gpio_stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: gpio_stable <= sync_d and cnt <= 0.
  - Else: cnt <= cnt+1.
- Debounce latency: a pin change set up before edge 1 and held updates gpio_stable at edge DEBOUNCE_CYCLES+3 (7 with default).
- Debounce acceptance: a level held ≥ DEBOUNCE_CYCLES+1 cycles is accepted. A pulse ≤ DEBOUNCE_CYCLES cycles is ignored.
- A change that occurs mid-count restarts the count. There is no partial acceptance.
- Edge flags:
  - rise = new_stable & ~gpio_stable, evaluated on the cycle gpio_stable updates.
  - flags <= (flags & ~clr) | rise.
  - clr = flags when reading GPIO_EDGE_ADDR, else 0.
  - Set has priority: an edge arriving in the clearing cycle stays set.
- Address decode: compare addr_ram[ADDR_WIDTH-1:2] only; bits [1:0] are ignored. Each of the two addresses hits only its own word.
- Read, one-cycle latency, captured on the clock edge where enable_lw=1:
  - On hit of GPIO_IN_ADDR: rdata <= {zeros, gpio_stable}, data_sel <= 1.
  - On hit of GPIO_EDGE_ADDR: rdata <= {zeros, flags} (pre-clear value), data_sel <= 1.
  - Otherwise (miss, or enable_lw=0): rdata <= 0, data_sel <= 0.
- data_sel is high for exactly one cycle per hit. Back-to-back hits give consecutive results.
- Writes to either address are ignored; there is no write port.
- edge_pending is combinational from the flags register.
- Reset mid-debounce discards the count. After deassertion, the pins are re-evaluated from scratch and a pin already high must be re-qualified, producing a rising edge.

Test Plan:
- Reset, then gpio_pins=8'hA5 held → gpio_stable=8'hA5 at edge 7. Flags then hold 8'hA5 and edge_pending=1.
- gpio_stable=0, bit0 pulsed high for 3 cycles → gpio_stable stays 0, flags stay 0. A 5-cycle pulse → gpio_stable[0] rises, then falls after release.
- gpio_stable=8'h3C, enable_lw=1, addr_ram=32'h1001_0028 → next cycle rdata=32'h0000_003C and data_sel=1 for one cycle. A second identical read returns the same value with no side effect.
- flags=8'h05, lw to 32'h1001_002C → rdata=32'h05 and flags become 0. A second read returns 0.
- flags=8'h01, a bit1 rising edge committed in the same cycle as the edge-flag read → rdata=32'h01, flags afterwards=8'h02.
- lw to 32'h1001_0030 or to RAM address 32'h1001_0000 → data_sel=0, rdata=0. Asserting reset at debounce count 2 → gpio_stable, rdata and data_sel are 0 immediately (asynchronous). After release, a held input is re-accepted at edge 7.
